ctrl_pipeline: RTL and testbench
================================

CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. clk_i and rst_i SHALL be named as the codebase does.
REQ-002 clk_i  input  1  core clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 RegDst_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i, Branch_i, Jump_i  input  1 each  decoded ID-stage control.
REQ-005 ALUOp_i  input  2  decoded ALU class: 00 add, 10 R-type.
REQ-006 RsAddr_i, RtAddr_i, RdAddr_i  input  5 each  register fields of the instruction in ID.
REQ-007 Flush_i  input  1  taken branch or jump resolved; squash the ID instruction.
REQ-008 EX outputs  output  1/2  ALUOp_ex_o[1:0], ALUSrc_ex_o, Branch_ex_o, Jump_ex_o.
REQ-009 MEM outputs  output  1  MemRead_mem_o, MemWrite_mem_o.
REQ-010 WB outputs  output  1/5  RegWrite_wb_o, MemtoReg_wb_o, WrAddr_wb_o[4:0].
REQ-011 Stall_o  output  1  hold PC and IF/ID (load-use hazard).
REQ-012 ForwardA_o, ForwardB_o  output  2 each  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.

Function
REQ-013 Stage registers SHALL be ID/EX, EX/MEM and MEM/WB. Control reaches EX 1 cycle after ID, MEM after 2, and WB after 3.
REQ-014 ID/EX SHALL capture all nine control inputs plus Rs, Rt and Rd each cycle unless a bubble is inserted.
REQ-015 WrAddr in EX SHALL be RegDst ? Rd : Rt. It SHALL be captured into EX/MEM and then into MEM/WB.
REQ-016 The load-use hazard SHALL be detected combinationally: Stall_o=1 iff ID/EX MemRead=1, ID/EX Rt≠0, and ID/EX Rt equals RsAddr_i or RtAddr_i.
REQ-017 A bubble SHALL load ID/EX with all control zero. Rs, Rt and Rd SHALL be zeroed in a bubble.
REQ-018 A bubble SHALL be inserted when Stall_o=1 or Flush_i=1.
REQ-019 Priority SHALL be rst_i > Flush_i > stall > normal. Simultaneous flush and stall SHALL yield one bubble.
REQ-020 EX/MEM and MEM/WB SHALL always advance and SHALL never stall.
REQ-021 ForwardA_o SHALL be 10 when EX/MEM RegWrite=1, EX/MEM WrAddr≠0 and EX/MEM WrAddr equals ID/EX Rs.
REQ-022 Otherwise ForwardA_o SHALL be 01 if the same conditions hold for MEM/WB; otherwise 00. ForwardB_o SHALL follow the same rule using ID/EX Rt.
REQ-023 When EX/MEM and MEM/WB both match, EX/MEM SHALL win.
REQ-024 Register 0 SHALL never be forwarded and SHALL never cause a stall.
REQ-025 Stall_o and Forward*_o SHALL be purely combinational from current stage registers and ID inputs, with zero latency.
REQ-026 A stall SHALL last exactly one cycle per load-use pair, since the bubble clears ID/EX MemRead.

Reset
REQ-027 On rst_i=1 at a clock edge, every stage register SHALL clear to zero. As a result, all outputs SHALL read 0 on the following cycle, including Stall_o=0 and Forward*_o=00.
REQ-028 Reset asserted mid-stall SHALL discard the pending bubble. No partial state SHALL survive.
REQ-029 Inputs sampled while rst_i=1 SHALL be ignored.

Structure
REQ-030 Package ctrl_pkg SHALL hold the ALUOp encodings (ALUOP_ADD=00, ALUOP_RTYPE=10), the forward-select constants (FWD_REG, FWD_EXMEM, FWD_MEMWB), and a packed control-bundle typedef used by all three stage registers.
REQ-031 Sub-module hazard_unit SHALL contain the stall and forwarding comparators. The stage registers SHALL remain in ctrl_pipeline.

Verification
REQ-032 Reset then idle: rst_i=1 for 2 cycles -> all outputs 0, Stall_o=0.
REQ-033 Pass-through: lw controls (ALUSrc=1, RegWrite=1, MemRead=1, MemtoReg=1, Rt=8) -> ALUSrc_ex_o=1 at +1, MemRead_mem_o=1 at +2, RegWrite_wb_o=1 with WrAddr_wb_o=8 at +3.
REQ-034 Load-use: lw Rt=8 then an instruction with RsAddr_i=8 -> Stall_o=1 for one cycle, bubble in EX at next cycle, Stall_o=0 after.
REQ-035 Forward priority: add writing $9 (RegDst=1, Rd=9), twice back-to-back, then an instruction with Rs=9 in EX -> ForwardA_o=10. With the second add replaced by a non-writer -> 01.
REQ-036 Zero register: lw Rt=0 then Rs=0 -> Stall_o=0; write to $0 -> Forward*_o=00.
REQ-037 Flush with simultaneous stall, and reset mid-stall -> single bubble, Branch_ex_o=0; after reset all outputs 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the control pipeline: ALU class encodings, forward selects,
// the control bundle carried by every stage register, and the forwarding rule.
package ctrl_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b10,
    FWD_MEMWB = 2'b01
  } fwd_sel_e;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t      ctrl;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } id_ex_t;

  typedef struct packed {
    ctrl_t      ctrl;
    logic [4:0] wr_addr;
  } late_stage_t;

  // EX/MEM is checked first so the younger result wins; $0 never forwards.
  function automatic fwd_sel_e fwd_select(
    input logic [4:0] src,
    input logic       ex_mem_we,
    input logic [4:0] ex_mem_wa,
    input logic       mem_wb_we,
    input logic [4:0] mem_wb_wa
  );
    if (ex_mem_we && (ex_mem_wa != 5'd0) && (ex_mem_wa == src)) return FWD_EXMEM;
    if (mem_wb_we && (mem_wb_wa != 5'd0) && (mem_wb_wa == src)) return FWD_MEMWB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Bus between the decoder and the control pipeline: decoded ID-stage control in,
// staged control, stall and forward selects out.
interface ctrl_pipeline_if;

  logic       RegDst_i;
  logic       ALUSrc_i;
  logic       RegWrite_i;
  logic       MemWrite_i;
  logic       MemRead_i;
  logic       MemtoReg_i;
  logic       Branch_i;
  logic       Jump_i;
  logic [1:0] ALUOp_i;
  logic [4:0] RsAddr_i;
  logic [4:0] RtAddr_i;
  logic [4:0] RdAddr_i;
  logic       Flush_i;

  logic [1:0] ALUOp_ex_o;
  logic       ALUSrc_ex_o;
  logic       Branch_ex_o;
  logic       Jump_ex_o;
  logic       MemRead_mem_o;
  logic       MemWrite_mem_o;
  logic       RegWrite_wb_o;
  logic       MemtoReg_wb_o;
  logic [4:0] WrAddr_wb_o;
  logic       Stall_o;
  logic [1:0] ForwardA_o;
  logic [1:0] ForwardB_o;

  modport master (
    output RegDst_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i,
           Branch_i, Jump_i, ALUOp_i, RsAddr_i, RtAddr_i, RdAddr_i, Flush_i,
    input  ALUOp_ex_o, ALUSrc_ex_o, Branch_ex_o, Jump_ex_o, MemRead_mem_o,
           MemWrite_mem_o, RegWrite_wb_o, MemtoReg_wb_o, WrAddr_wb_o, Stall_o,
           ForwardA_o, ForwardB_o
  );

  modport slave (
    input  RegDst_i, ALUSrc_i, RegWrite_i, MemWrite_i, MemRead_i, MemtoReg_i,
           Branch_i, Jump_i, ALUOp_i, RsAddr_i, RtAddr_i, RdAddr_i, Flush_i,
    output ALUOp_ex_o, ALUSrc_ex_o, Branch_ex_o, Jump_ex_o, MemRead_mem_o,
           MemWrite_mem_o, RegWrite_wb_o, MemtoReg_wb_o, WrAddr_wb_o, Stall_o,
           ForwardA_o, ForwardB_o
  );

endinterface

// File: rtl/hazard_unit.sv
// Load-use stall detection and EX operand forwarding; purely combinational so
// both act in the same cycle the hazard is visible in the stage registers.
module hazard_unit
  import ctrl_pkg::*;
(
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rs,
  input  logic [4:0] id_ex_rt,
  input  logic [4:0] rs_addr,
  input  logic [4:0] rt_addr,
  input  logic       ex_mem_reg_write,
  input  logic [4:0] ex_mem_wr_addr,
  input  logic       mem_wb_reg_write,
  input  logic [4:0] mem_wb_wr_addr,
  output logic       stall,
  output fwd_sel_e   fwd_a,
  output fwd_sel_e   fwd_b
);

  // A load into $0 produces nothing a consumer can wait on.
  assign stall = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                 ((id_ex_rt == rs_addr) || (id_ex_rt == rt_addr));

  assign fwd_a = fwd_select(id_ex_rs, ex_mem_reg_write, ex_mem_wr_addr,
                            mem_wb_reg_write, mem_wb_wr_addr);
  assign fwd_b = fwd_select(id_ex_rt, ex_mem_reg_write, ex_mem_wr_addr,
                            mem_wb_reg_write, mem_wb_wr_addr);

endmodule

// File: rtl/ctrl_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control stage registers with bubble insertion on
// load-use stall or flush; hazard comparators live in hazard_unit.
module ctrl_pipeline
  import ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  ctrl_pipeline_if.slave  bus
);

  id_ex_t      id_ex;
  late_stage_t ex_mem;
  late_stage_t mem_wb;

  ctrl_t       id_ctrl;
  logic [4:0]  ex_wr_addr;
  logic        stall;
  fwd_sel_e    fwd_a;
  fwd_sel_e    fwd_b;

  assign id_ctrl = '{
    reg_dst:    bus.RegDst_i,
    alu_src:    bus.ALUSrc_i,
    reg_write:  bus.RegWrite_i,
    mem_write:  bus.MemWrite_i,
    mem_read:   bus.MemRead_i,
    mem_to_reg: bus.MemtoReg_i,
    branch:     bus.Branch_i,
    jump:       bus.Jump_i,
    alu_op:     bus.ALUOp_i
  };

  assign ex_wr_addr = id_ex.ctrl.reg_dst ? id_ex.rd : id_ex.rt;

  // NOTE: every stage register uses <= so all three stages sample the
  // pre-edge values of their predecessors; blocking here would collapse stages.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: reset is synchronous; it also overrides a pending bubble, so no
      // half-inserted state can survive it.
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      if (bus.Flush_i || stall) begin
        id_ex <= '0;
      end else begin
        id_ex <= '{ctrl: id_ctrl, rs: bus.RsAddr_i, rt: bus.RtAddr_i, rd: bus.RdAddr_i};
      end
      ex_mem <= '{ctrl: id_ex.ctrl, wr_addr: ex_wr_addr};
      mem_wb <= ex_mem;
    end
  end

  hazard_unit u_hazard (
    .id_ex_mem_read   (id_ex.ctrl.mem_read),
    .id_ex_rs         (id_ex.rs),
    .id_ex_rt         (id_ex.rt),
    .rs_addr          (bus.RsAddr_i),
    .rt_addr          (bus.RtAddr_i),
    .ex_mem_reg_write (ex_mem.ctrl.reg_write),
    .ex_mem_wr_addr   (ex_mem.wr_addr),
    .mem_wb_reg_write (mem_wb.ctrl.reg_write),
    .mem_wb_wr_addr   (mem_wb.wr_addr),
    .stall            (stall),
    .fwd_a            (fwd_a),
    .fwd_b            (fwd_b)
  );

  assign bus.ALUOp_ex_o     = id_ex.ctrl.alu_op;
  assign bus.ALUSrc_ex_o    = id_ex.ctrl.alu_src;
  assign bus.Branch_ex_o    = id_ex.ctrl.branch;
  assign bus.Jump_ex_o      = id_ex.ctrl.jump;
  assign bus.MemRead_mem_o  = ex_mem.ctrl.mem_read;
  assign bus.MemWrite_mem_o = ex_mem.ctrl.mem_write;
  assign bus.RegWrite_wb_o  = mem_wb.ctrl.reg_write;
  assign bus.MemtoReg_wb_o  = mem_wb.ctrl.mem_to_reg;
  assign bus.WrAddr_wb_o    = mem_wb.wr_addr;
  assign bus.Stall_o        = stall;
  assign bus.ForwardA_o     = fwd_a;
  assign bus.ForwardB_o     = fwd_b;

  // The WB stage only consumes its write-back fields of the shared bundle.
  logic unused_mem_wb;
  assign unused_mem_wb = ^{mem_wb.ctrl.reg_dst, mem_wb.ctrl.alu_src,
                           mem_wb.ctrl.mem_write, mem_wb.ctrl.mem_read,
                           mem_wb.ctrl.branch, mem_wb.ctrl.jump,
                           mem_wb.ctrl.alu_op};

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: pass-through latency, load-use stall,
// forwarding priority, $0 handling, flush/stall bubbles and reset.
module tb_ctrl_pipeline;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  ctrl_pipeline_if bus ();

  ctrl_pipeline dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam ctrl_t C_NOP = '0;
  localparam ctrl_t C_LW  = '{reg_dst:1'b0, alu_src:1'b1, reg_write:1'b1, mem_write:1'b0,
                              mem_read:1'b1, mem_to_reg:1'b1, branch:1'b0, jump:1'b0,
                              alu_op:ALUOP_ADD};
  localparam ctrl_t C_ADD = '{reg_dst:1'b1, alu_src:1'b0, reg_write:1'b1, mem_write:1'b0,
                              mem_read:1'b0, mem_to_reg:1'b0, branch:1'b0, jump:1'b0,
                              alu_op:ALUOP_RTYPE};
  localparam ctrl_t C_SW  = '{reg_dst:1'b0, alu_src:1'b1, reg_write:1'b0, mem_write:1'b1,
                              mem_read:1'b0, mem_to_reg:1'b0, branch:1'b0, jump:1'b0,
                              alu_op:ALUOP_ADD};
  localparam ctrl_t C_BEQ = '{reg_dst:1'b0, alu_src:1'b0, reg_write:1'b0, mem_write:1'b0,
                              mem_read:1'b0, mem_to_reg:1'b0, branch:1'b1, jump:1'b0,
                              alu_op:2'b01};
  localparam ctrl_t C_J   = '{reg_dst:1'b0, alu_src:1'b0, reg_write:1'b0, mem_write:1'b0,
                              mem_read:1'b0, mem_to_reg:1'b0, branch:1'b0, jump:1'b1,
                              alu_op:ALUOP_ADD};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic drive(input ctrl_t c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic flush);
    bus.RegDst_i   = c.reg_dst;
    bus.ALUSrc_i   = c.alu_src;
    bus.RegWrite_i = c.reg_write;
    bus.MemWrite_i = c.mem_write;
    bus.MemRead_i  = c.mem_read;
    bus.MemtoReg_i = c.mem_to_reg;
    bus.Branch_i   = c.branch;
    bus.Jump_i     = c.jump;
    bus.ALUOp_i    = c.alu_op;
    bus.RsAddr_i   = rs;
    bus.RtAddr_i   = rt;
    bus.RdAddr_i   = rd;
    bus.Flush_i    = flush;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (3) tick();
  endtask

  // All 19 output bits in one word, so "everything is zero" is one comparison.
  function automatic logic [31:0] all_outs();
    return {13'd0, bus.ALUOp_ex_o, bus.ALUSrc_ex_o, bus.Branch_ex_o, bus.Jump_ex_o,
            bus.MemRead_mem_o, bus.MemWrite_mem_o, bus.RegWrite_wb_o, bus.MemtoReg_wb_o,
            bus.WrAddr_wb_o, bus.Stall_o, bus.ForwardA_o, bus.ForwardB_o};
  endfunction

  function automatic logic [31:0] ex_ctrl();
    return {27'd0, bus.ALUOp_ex_o, bus.ALUSrc_ex_o, bus.Branch_ex_o, bus.Jump_ex_o};
  endfunction

  initial begin
    // Reset with a load presented on the inputs: it must be ignored.
    drive(C_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    check("reset_all_zero", all_outs(), 32'd0);
    check("reset_stall", {31'd0, bus.Stall_o}, 32'd0);

    // Pass-through of a load: EX at +1, MEM at +2, WB at +3.
    drive(C_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    tick();
    drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    check("pt_alusrc_ex", {31'd0, bus.ALUSrc_ex_o}, 32'd1);
    check("pt_memread_mem_early", {31'd0, bus.MemRead_mem_o}, 32'd0);
    tick();
    check("pt_memread_mem", {31'd0, bus.MemRead_mem_o}, 32'd1);
    check("pt_alusrc_ex_clear", {31'd0, bus.ALUSrc_ex_o}, 32'd0);
    tick();
    check("pt_regwrite_wb", {31'd0, bus.RegWrite_wb_o}, 32'd1);
    check("pt_wraddr_wb", {27'd0, bus.WrAddr_wb_o}, 32'd8);
    check("pt_memtoreg_wb", {31'd0, bus.MemtoReg_wb_o}, 32'd1);
    drain();

    // Load-use: lw $8 then add using $8 as Rs.
    drive(C_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    tick();
    drive(C_ADD, 5'd8, 5'd3, 5'd10, 1'b0);
    #1;
    check("lu_stall", {31'd0, bus.Stall_o}, 32'd1);
    tick();
    check("lu_bubble_ex", ex_ctrl(), 32'd0);
    check("lu_stall_released", {31'd0, bus.Stall_o}, 32'd0);
    tick();
    drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    check("lu_add_in_ex", {30'd0, bus.ALUOp_ex_o}, {30'd0, ALUOP_RTYPE});
    check("lu_fwd_a_memwb", {30'd0, bus.ForwardA_o}, 32'd1);
    check("lu_no_restall", {31'd0, bus.Stall_o}, 32'd0);
    drain();

    // Forwarding priority: two writers of $9, then a consumer of $9.
    drive(C_ADD, 5'd1, 5'd2, 5'd9, 1'b0);
    tick();
    drive(C_ADD, 5'd1, 5'd2, 5'd9, 1'b0);
    tick();
    drive(C_ADD, 5'd9, 5'd4, 5'd11, 1'b0);
    tick();
    check("fwd_a_exmem_wins", {30'd0, bus.ForwardA_o}, 32'd2);
    check("fwd_b_none", {30'd0, bus.ForwardB_o}, 32'd0);
    // Writer of $9, then a store (no write), then a consumer of $9 on both ports.
    drive(C_ADD, 5'd1, 5'd2, 5'd9, 1'b0);
    tick();
    drive(C_SW, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    drive(C_ADD, 5'd9, 5'd9, 5'd12, 1'b0);
    tick();
    check("fwd_a_memwb", {30'd0, bus.ForwardA_o}, 32'd1);
    check("fwd_b_memwb", {30'd0, bus.ForwardB_o}, 32'd1);
    drive(C_ADD, 5'd0, 5'd12, 5'd13, 1'b0);
    tick();
    check("fwd_b_exmem", {30'd0, bus.ForwardB_o}, 32'd2);
    check("fwd_a_rs0", {30'd0, bus.ForwardA_o}, 32'd0);
    drain();

    // $0 never stalls and is never forwarded.
    drive(C_LW, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    drive(C_ADD, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    check("zero_no_stall", {31'd0, bus.Stall_o}, 32'd0);
    tick();
    check("zero_fwd_exmem", {28'd0, bus.ForwardA_o, bus.ForwardB_o}, 32'd0);
    drive(C_ADD, 5'd0, 5'd0, 5'd5, 1'b0);
    tick();
    check("zero_fwd_both", {28'd0, bus.ForwardA_o, bus.ForwardB_o}, 32'd0);
    drain();

    // Branch reaches EX normally; a flushed jump does not.
    drive(C_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    check("branch_ex", {31'd0, bus.Branch_ex_o}, 32'd1);
    drive(C_J, 5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    check("flush_bubble", ex_ctrl(), 32'd0);
    drain();

    // Flush together with a load-use stall: one bubble only.
    drive(C_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    tick();
    drive(C_BEQ, 5'd8, 5'd2, 5'd0, 1'b1);
    #1;
    check("fs_stall", {31'd0, bus.Stall_o}, 32'd1);
    tick();
    drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    check("fs_branch_ex", {31'd0, bus.Branch_ex_o}, 32'd0);
    check("fs_bubble_ex", ex_ctrl(), 32'd0);
    check("fs_stall_once", {31'd0, bus.Stall_o}, 32'd0);
    tick();
    check("fs_still_clear", {31'd0, bus.Stall_o | bus.Branch_ex_o}, 32'd0);
    drain();

    // Reset arriving mid-stall with live state in every stage.
    drive(C_ADD, 5'd1, 5'd2, 5'd7, 1'b0);
    tick();
    drive(C_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    tick();
    drive(C_ADD, 5'd8, 5'd3, 5'd4, 1'b0);
    #1;
    check("rs_stall_before", {31'd0, bus.Stall_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    check("rs_all_zero", all_outs(), 32'd0);
    tick();
    check("rs_all_zero_next", all_outs(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
